seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot; SHALL be >= 2.
REQ-002 Parameter BLANK_CYCLES, default 16: blank cycles at the start of each slot; SHALL be < REFRESH_DIV.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  scan enable; 0 freezes scanning and turns all digits off.
REQ-006 Port digit_mask  input  4  per-digit enable; bit i=0 keeps digit i dark during its slot.
REQ-007 Port s0  output  1  select LSB to the downstream 4:1 7-bit segment mux.
REQ-008 Port s1  output  1  select MSB to the downstream 4:1 7-bit segment mux.
REQ-009 Port an  output  4  digit anodes, active-low, at most one bit low.
REQ-010 Port tick  output  1  one-cycle pulse on each slot change.
REQ-011 Port blank  output  1  high while in the BLANK state.

Function
REQ-012 Prescaler cnt SHALL count 0..REFRESH_DIV-1 on each clk with en=1 and SHALL wrap to 0 after REFRESH_DIV-1.
REQ-013 Digit index idx (2 bits) SHALL advance by 1 on the wrap edge, 3 -> 0 wrap; idx SHALL NOT change otherwise.
REQ-014 {s1,s0} SHALL equal idx: idx 0 selects mux input a, 1 selects b, 2 selects c, 3 selects d.
REQ-015 tick SHALL be 1 for exactly the cycle following each idx advance, otherwise 0.
REQ-016 State machine: DISPLAY and BLANK; on an idx advance the state SHALL go to BLANK, and after BLANK_CYCLES cycles in BLANK it SHALL return to DISPLAY.
REQ-017 BLANK_CYCLES=0 SHALL skip BLANK entirely.
REQ-018 In DISPLAY with en=1, an[i] SHALL be 0 iff i==idx and digit_mask[i]=1; all other an bits SHALL be 1.
REQ-019 In BLANK, an SHALL be 4'b1111 and blank SHALL be 1.
REQ-020 an, s0, s1, tick and blank SHALL be registered and SHALL change on the same clk edge as idx/state; no combinational input-to-output path.
REQ-021 en=0: cnt, idx, state and the blank counter SHALL hold, an SHALL be 4'b1111 on the next edge, and tick SHALL be 0.
REQ-022 en 0->1: scanning SHALL resume from the held cnt, idx and state without restarting the slot.
REQ-023 A digit_mask change SHALL take effect on the next clk edge, mid-slot included.
REQ-024 Slot period SHALL be exactly REFRESH_DIV enabled cycles; BLANK time SHALL be part of the slot, not added to it.

Reset
REQ-025 rst=1 at a clk edge SHALL force cnt=0, idx=0, state=DISPLAY, blank counter=0, s0=s1=0, an=4'b1111, tick=0 and blank=0, regardless of other inputs or mid-slot/mid-blank position.
REQ-026 First edge after rst release with en=1 and digit_mask[0]=1 SHALL drive an=4'b1110; no BLANK is inserted after reset.

Configuration
REQ-027 Macro SEG_GHOST_BLANK_EN defined: the BLANK state, the blank counter and the blank output behave per REQ-016, REQ-017 and REQ-019.
REQ-028 Macro SEG_GHOST_BLANK_EN undefined: no BLANK state or blank counter is built, the state is always DISPLAY, blank is tied 0, and BLANK_CYCLES is ignored.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, macro defined unless stated)
REQ-029 rst for 2 cycles, then en=1, mask=4'b1111 -> an sequence 1110 x4 cycles, then 1111 x1, 1101 x3, 1111 x1, 1011 x3, 1111 x1, 0111 x3, then back to idx 0; {s1,s0} steps 0,1,2,3,0; tick pulses every 4 cycles.
REQ-030 mask=4'b0101, en=1, full rotation -> an low only during slots 0 and 2; slots 1 and 3 read 1111 for all 4 cycles while s0/s1 still step.
REQ-031 en=0 for 5 cycles at cnt=2, idx=1 -> an=1111 and idx/cnt frozen; after en=1, idx advances 2 enabled cycles later.
REQ-032 rst asserted during BLANK of slot 2 -> next edge idx=0, an=1111, blank=0; after release an=1110.
REQ-033 Macro undefined, same stimulus as REQ-029 -> blank is always 0; an reads 1110, 1101, 1011, 0111 for 4 cycles each.
REQ-034 All runs -> assertions hold: an never has more than one 0 bit, and tick is never high for two consecutive cycles.

Source files
------------

// File: rtl/seg_scan_if.sv
// Digit-scan bus between the scan controller and its user.
// The user drives enable and mask; the controller returns mux selects, anodes and status.
interface seg_scan_if;
    logic       en;
    logic [3:0] digit_mask;
    logic       s0;
    logic       s1;
    logic [3:0] an;
    logic       tick;
    logic       blank;

    modport master (
        output en,
        output digit_mask,
        input  s0,
        input  s1,
        input  an,
        input  tick,
        input  blank
    );

    modport slave (
        input  en,
        input  digit_mask,
        output s0,
        output s1,
        output an,
        output tick,
        output blank
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with registered anode/select outputs.
// Define SEG_GHOST_BLANK_EN to add anti-ghosting BLANK cycles at the start of each slot.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input logic        clk,
    input logic        rst,
    seg_scan_if.slave  io_scan
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx;
    logic            r_armed;
    logic            w_armed;
    logic [3:0]      r_an;
    logic [3:0]      w_an;
    logic            r_tick;
    logic            w_tick;
    logic            w_show;

`ifdef SEG_GHOST_BLANK_EN
    localparam int unsigned BlkW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BlkW-1:0] BlkLast = BlkW'(BLANK_CYCLES - 1);

    typedef enum logic {StDisplay, StBlank} state_e;

    state_e          r_state;
    state_e          w_state;
    logic [BlkW-1:0] r_bcnt;
    logic [BlkW-1:0] w_bcnt;
    logic            r_blank;
`endif

    always_comb begin
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_armed = r_armed;
        w_an    = 4'b1111;
        w_tick  = 1'b0;
        w_show  = 1'b1;
`ifdef SEG_GHOST_BLANK_EN
        w_state = r_state;
        w_bcnt  = r_bcnt;
`endif
        if (io_scan.en) begin
            // First enabled edge after reset only lights digit 0, so slot 0 lasts a full period.
            w_armed = 1'b1;
            if (r_armed) begin
                if (r_cnt == CntMax) begin
                    w_cnt  = '0;
                    w_idx  = r_idx + 2'd1;
                    w_tick = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`ifdef SEG_GHOST_BLANK_EN
            if (w_tick) begin
                if (BLANK_CYCLES != 0) begin
                    w_state = StBlank;
                    w_bcnt  = '0;
                end
            end else if (r_state == StBlank) begin
                if (r_bcnt == BlkLast) begin
                    w_state = StDisplay;
                end else begin
                    w_bcnt = r_bcnt + 1'b1;
                end
            end
            w_show = (w_state == StDisplay);
`endif
            if (w_show && io_scan.digit_mask[w_idx]) begin
                w_an = ~(4'b0001 << w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_armed <= 1'b0;
            r_an    <= 4'b1111;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_armed <= w_armed;
            r_an    <= w_an;
            r_tick  <= w_tick;
        end
    end

`ifdef SEG_GHOST_BLANK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StDisplay;
            r_bcnt  <= '0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_state;
            r_bcnt  <= w_bcnt;
            r_blank <= (w_state == StBlank);
        end
    end

    assign io_scan.blank = r_blank;
`else
    assign io_scan.blank = 1'b0;
`endif

    assign io_scan.s0   = r_idx[0];
    assign io_scan.s1   = r_idx[1];
    assign io_scan.an   = r_an;
    assign io_scan.tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed table-driven bench for seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=1.
// Expectations follow SEG_GHOST_BLANK_EN the same way the design does.
module tb_seg_scan_ctrl;

`ifdef SEG_GHOST_BLANK_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] mask;
        logic [3:0] an;
        logic [1:0] s;
        logic       tick;
        logic       blank;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [$];
    logic prev_tick = 1'b0;

    seg_scan_if u_if ();

    seg_scan_ctrl #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .io_scan (u_if)
    );

    always #5 clk = ~clk;

    // Structural invariants, sampled mid-cycle every cycle.
    always @(negedge clk) begin
        n_checks++;
        if ($countones(~u_if.an) > 1) begin
            n_errors++;
            $display("FAIL onehot_an: an=%b has more than one low bit", u_if.an);
        end
        n_checks++;
        if (prev_tick && u_if.tick) begin
            n_errors++;
            $display("FAIL tick_double: tick high two cycles in a row, got 1 required 0");
        end
        prev_tick = u_if.tick;
    end

    task automatic add(input logic r, input logic e, input logic [3:0] m,
                       input logic [3:0] a, input logic [1:0] s, input logic t, input logic b);
        vec_t v;
        v.rst = r; v.en = e; v.mask = m; v.an = a; v.s = s; v.tick = t; v.blank = b;
        vecs.push_back(v);
    endtask

    task automatic addn(input int n, input logic r, input logic e, input logic [3:0] m,
                        input logic [3:0] a, input logic [1:0] s, input logic t, input logic b);
        for (int k = 0; k < n; k++) add(r, e, m, a, s, t, b);
    endtask

    task automatic chk(input string name, input int i, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %b required %b", name, i, act, exp);
        end
    endtask

    initial begin
        int last_tick;
        int ticks;

        // Reset for two cycles, the second with inputs active.
        add (1, 0, 4'hF, 4'hF, 0, 0, 0);
        add (1, 1, 4'hF, 4'hF, 0, 0, 0);
        // Full rotation, mask 1111.
        addn(4, 0, 1, 4'hF, 4'hE, 0, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'hD, 1, 1, G);
        addn(3, 0, 1, 4'hF, 4'hD, 1, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'hB, 2, 1, G);
        addn(3, 0, 1, 4'hF, 4'hB, 2, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'h7, 3, 1, G);
        addn(3, 0, 1, 4'hF, 4'h7, 3, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'hE, 0, 1, G);
        // Mask 0101: slots 1 and 3 stay dark while selects still step.
        addn(3, 0, 1, 4'h5, 4'hE, 0, 0, 0);
        add (0, 1, 4'h5, 4'hF, 1, 1, G);
        addn(3, 0, 1, 4'h5, 4'hF, 1, 0, 0);
        add (0, 1, 4'h5, G ? 4'hF : 4'hB, 2, 1, G);
        addn(3, 0, 1, 4'h5, 4'hB, 2, 0, 0);
        add (0, 1, 4'h5, 4'hF, 3, 1, G);
        addn(3, 0, 1, 4'h5, 4'hF, 3, 0, 0);
        add (0, 1, 4'h5, G ? 4'hF : 4'hE, 0, 1, G);
        // Mid-slot mask changes act on the next edge.
        add (0, 1, 4'h5, 4'hE, 0, 0, 0);
        add (0, 1, 4'h0, 4'hF, 0, 0, 0);
        add (0, 1, 4'hF, 4'hE, 0, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'hD, 1, 1, G);
        addn(2, 0, 1, 4'hF, 4'hD, 1, 0, 0);
        // Freeze at cnt=2, idx=1 for 5 cycles; resume needs 2 enabled edges to advance.
        addn(5, 0, 0, 4'hF, 4'hF, 1, 0, 0);
        add (0, 1, 4'hF, 4'hD, 1, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'hB, 2, 1, G);
        // Reset during the start of slot 2 (BLANK when enabled).
        add (1, 1, 4'hF, 4'hF, 0, 0, 0);
        addn(4, 0, 1, 4'hF, 4'hE, 0, 0, 0);
        add (0, 1, 4'hF, G ? 4'hF : 4'hD, 1, 1, G);

        u_if.en = 1'b0;
        u_if.digit_mask = 4'hF;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            u_if.en = vecs[i].en;
            u_if.digit_mask = vecs[i].mask;
            @(posedge clk);
            #1;
            chk("an", i, u_if.an, vecs[i].an);
            chk("sel", i, {2'b00, u_if.s1, u_if.s0}, {2'b00, vecs[i].s});
            chk("tick", i, {3'b000, u_if.tick}, {3'b000, vecs[i].tick});
            chk("blank", i, {3'b000, u_if.blank}, {3'b000, vecs[i].blank});
        end

        // Tick spacing over a bounded free-running window must be exactly 4 enabled cycles.
        last_tick = -1;
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rst = 1'b0;
            u_if.en = 1'b1;
            @(posedge clk);
            #1;
            if (u_if.tick) begin
                if (last_tick >= 0) begin
                    chk("tick_period", c, 4'(c - last_tick), 4'd4);
                end
                last_tick = c;
                ticks++;
            end
        end
        chk("tick_count", 0, 4'(ticks), 4'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
